iir_coeff_ctrl: RTL

IIR_COEFF_CTRL -- requirements
Module: iir_coeff_ctrl

---
 rtl/iir_coeff_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/iir_coeff_ctrl.sv
// Double-banked biquad coefficient store: shadow writes, strobe-aligned atomic swap, then filter flush.
// Optional macro IIR_COEFF_READBACK_EN adds a registered shadow-bank read port (rd_addr/rd_data).
module iir_coeff_ctrl #(
  parameter int COEFF_WIDTH  = 32,
  parameter int NUM_SECTIONS = 3,
  parameter int SCALE_SHIFT  = 20,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [3:0]                             cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0]          cfg_data,
  input  logic                                   commit,
  input  logic                                   sample_strobe,
  output logic [5*NUM_SECTIONS*COEFF_WIDTH-1:0]  coeff_bus,
  output logic                                   filt_flush_n,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   cfg_err
`ifdef IIR_COEFF_READBACK_EN
  ,
  input  logic [3:0]                             rd_addr,
  output logic [COEFF_WIDTH-1:0]                 rd_data
`endif
);

  localparam int NCOEF = 5 * NUM_SECTIONS;
  localparam logic [COEFF_WIDTH-1:0] PASS_B0 = COEFF_WIDTH'(1) << SCALE_SHIFT;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SWAP, FLUSH} state_t;

  // Passthrough biquad: b0 = 1.0 in fixed point, everything else zero.
  function automatic logic [COEFF_WIDTH-1:0] pass_val(input int idx);
    return ((idx % 5) == 0) ? PASS_B0 : '0;
  endfunction

  state_t                 state_q, state_d;
  logic                   dirty_q, dirty_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   flush_n_q, flush_n_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [COEFF_WIDTH-1:0] shadow_q [NCOEF];
  logic [COEFF_WIDTH-1:0] shadow_d [NCOEF];
  logic [COEFF_WIDTH-1:0] active_q [NCOEF];
  logic [COEFF_WIDTH-1:0] active_d [NCOEF];

  logic cfg_legal;
  logic wr_acc;

  assign cfg_legal = ({28'd0, cfg_addr} < 32'(NCOEF));
  assign wr_acc    = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d   = state_q;
    dirty_d   = dirty_q;
    cfg_err_d = cfg_err_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;

    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          if (cfg_legal) begin
            shadow_d[cfg_addr] = cfg_data;
            dirty_d            = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // A legal write landing with commit is part of this update.
        if (commit && (dirty_q || (wr_acc && cfg_legal))) begin
          state_d = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        // The whole bank lands on the edge after the strobe so every tap changes together.
        if (sample_strobe) begin
          active_d = shadow_q;
          state_d  = SWAP;
        end
      end
      SWAP: begin
        dirty_d = 1'b0;
        cnt_d   = FLUSH_LAST;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered images of the next state.
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    flush_n_d   = (state_d != FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dirty_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      flush_n_q   <= 1'b1;
      cnt_q       <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= pass_val(i);
        active_q[i] <= pass_val(i);
      end
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      flush_n_q   <= flush_n_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    coeff_bus = '0;
    for (int i = 0; i < NCOEF; i++) begin
      coeff_bus[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[i];
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign filt_flush_n = flush_n_q;

`ifdef IIR_COEFF_READBACK_EN
  logic                   rd_legal;
  logic [COEFF_WIDTH-1:0] rd_data_q, rd_data_d;

  assign rd_legal = ({28'd0, rd_addr} < 32'(NCOEF));

  always_comb begin
    rd_data_d = '0;
    if (rd_legal) begin
      rd_data_d = shadow_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
